// File: rtl/irq_ctrl_pkg.sv
// Shared register map, bus widths and FSM encoding for the irq_ctrl slice.
package irq_ctrl_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 2;

  localparam logic [ADDR_W-1:0] IRQ_ADDR_MASK = 2'd0;
  localparam logic [ADDR_W-1:0] IRQ_ADDR_PEND = 2'd1;
  localparam logic [ADDR_W-1:0] IRQ_ADDR_ID   = 2'd2;
  localparam logic [ADDR_W-1:0] IRQ_ADDR_TCMP = 2'd3;

  typedef enum logic [1:0] {
    IRQ_IDLE = 2'd0,
    IRQ_REQ  = 2'd1,
    IRQ_SVC  = 2'd2,
    IRQ_GAP  = 2'd3
  } irq_state_e;

endpackage

// File: rtl/irq_ctrl_if.sv
// Interrupt lines, register port and CP0 handshake between core and controller.
interface irq_ctrl_if #(
  parameter int unsigned N_SRC = 8,
  parameter int unsigned ID_W  = 4
) ();
  import irq_ctrl_pkg::*;

  logic [N_SRC-1:0]  irq_src;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              ir_taken;
  logic              eret;
  logic              ir_in;
  logic [ID_W-1:0]   irq_id;

  modport master (
    output irq_src, wr_en, wr_addr, wr_data, rd_addr, ir_taken, eret,
    input  rd_data, ir_in, irq_id
  );

  modport slave (
    input  irq_src, wr_en, wr_addr, wr_data, rd_addr, ir_taken, eret,
    output rd_data, ir_in, irq_id
  );

endinterface

// File: rtl/irq_ctrl_sync.sv
// Two-flop synchroniser for one raw interrupt line plus a one-cycle rising-edge pulse.
module irq_ctrl_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic rise_c_o
);

  logic meta_q, sync_q, prev_q;

  // Synchroniser chain and edge-history flop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rise_c_o = sync_q & ~prev_q;

endmodule

// File: rtl/irq_ctrl.sv
// External interrupt controller feeding CP0 ir_in: edge-latched pending bits,
// mask, fixed lowest-index priority, and a REQ/SVC/GAP handshake with CP0.
// Optional timer source (id N_SRC, compare register at addr 3) under IRQ_TIMER_EN.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int unsigned N_SRC = 8,
  parameter int unsigned ID_W  = 4
) (
  input logic       clk,
  input logic       rst,
  irq_ctrl_if.slave bus
);

`ifdef IRQ_TIMER_EN
  localparam int unsigned N_ALL = N_SRC + 1;
`else
  localparam int unsigned N_ALL = N_SRC;
`endif

  logic [N_SRC-1:0] src_rise;
  logic [N_ALL-1:0] rise, mask_q, mask_d, pend_q, pend_d, req, sel, w1c, eret_clr;
  irq_state_e       state_q, state_d;
  logic [ID_W-1:0]  id_q, id_d, win;
  logic             cur_ok, relatch_q, relatch_d, ir_in_q, ir_in_d, eret_fire;
  logic             wr_mask, wr_pend, valid;
  logic             unused_wdata;

  for (genvar g = 0; g < int'(N_SRC); g++) begin : g_sync
    irq_ctrl_sync u_sync (
      .clk      (clk),
      .rst      (rst),
      .async_i  (bus.irq_src[g]),
      .rise_c_o (src_rise[g])
    );
  end

  assign wr_mask      = bus.wr_en && (bus.wr_addr == IRQ_ADDR_MASK);
  assign wr_pend      = bus.wr_en && (bus.wr_addr == IRQ_ADDR_PEND);
  assign unused_wdata = ^bus.wr_data;

`ifdef IRQ_TIMER_EN
  logic [DATA_W-1:0] cnt_q, cnt_d, tcmp_q, tcmp_d;
  logic              tmr_hit, wr_tcmp;

  assign wr_tcmp = bus.wr_en && (bus.wr_addr == IRQ_ADDR_TCMP);

  // Free-running counter; a new compare value restarts the count so the first period is exact.
  always_comb begin
    tmr_hit = (tcmp_q != '0) && (cnt_q == tcmp_q);
    tcmp_d  = tcmp_q;
    cnt_d   = tmr_hit ? '0 : cnt_q + 32'd1;
    if (wr_tcmp) begin
      tcmp_d = bus.wr_data;
      cnt_d  = '0;
    end
  end

  // Timer registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      tcmp_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      tcmp_q <= tcmp_d;
    end
  end

  assign rise = {tmr_hit, src_rise};
`else
  assign rise = src_rise;
`endif

  assign req    = pend_q & mask_q;
  assign sel    = N_ALL'(1) << id_q;
  assign cur_ok = |(sel & req);
  assign valid  = (state_q == IRQ_REQ) || (state_q == IRQ_SVC);

  // Fixed priority: lowest asserted index of PENDING & MASK.
  always_comb begin
    win = '0;
    for (int i = int'(N_ALL) - 1; i >= 0; i--) begin
      if (req[i]) win = ID_W'(i);
    end
  end

  // CP0 handshake FSM next state.
  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    eret_fire = 1'b0;
    unique case (state_q)
      IRQ_IDLE: begin
        if (|req) begin
          state_d = IRQ_REQ;
          id_d    = win;
        end
      end
      IRQ_REQ: begin
        if (!cur_ok)          state_d = IRQ_GAP;
        else if (bus.ir_taken) state_d = IRQ_SVC;
      end
      IRQ_SVC: begin
        if (bus.eret) begin
          eret_fire = 1'b1;
          state_d   = IRQ_GAP;
        end
      end
      IRQ_GAP:  state_d = IRQ_IDLE;
      default:  state_d = IRQ_IDLE;
    endcase
    ir_in_d = (state_d == IRQ_REQ) || (state_d == IRQ_SVC);
  end

  // Pending/mask update; an edge on the in-service source during SVC survives the ERET clear.
  always_comb begin
    w1c       = wr_pend ? bus.wr_data[N_ALL-1:0] : '0;
    eret_clr  = (eret_fire && !relatch_q) ? sel : '0;
    pend_d    = (pend_q & ~w1c & ~eret_clr) | rise;
    mask_d    = wr_mask ? bus.wr_data[N_ALL-1:0] : mask_q;
    relatch_d = (state_q == IRQ_SVC) && (relatch_q || |(rise & sel));
  end

  // Controller state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IRQ_IDLE;
      id_q      <= '0;
      mask_q    <= '0;
      pend_q    <= '0;
      relatch_q <= 1'b0;
      ir_in_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      mask_q    <= mask_d;
      pend_q    <= pend_d;
      relatch_q <= relatch_d;
      ir_in_q   <= ir_in_d;
    end
  end

  // Combinational register read port, zero-extended.
  always_comb begin
    bus.rd_data = '0;
    unique case (bus.rd_addr)
      IRQ_ADDR_MASK: bus.rd_data = DATA_W'(mask_q);
      IRQ_ADDR_PEND: bus.rd_data = DATA_W'(pend_q);
      IRQ_ADDR_ID:   bus.rd_data = {valid, {(DATA_W - 1 - ID_W){1'b0}}, id_q};
`ifdef IRQ_TIMER_EN
      IRQ_ADDR_TCMP: bus.rd_data = tcmp_q;
`endif
      default:       bus.rd_data = '0;
    endcase
  end

  assign bus.ir_in  = ir_in_q;
  assign bus.irq_id = id_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl; expected request ids are queued when stimulus
// is driven and popped when ir_in rises.
module tb_irq_ctrl;
  import irq_ctrl_pkg::*;

  localparam int unsigned NS = 8;
  localparam int unsigned IW = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;

  irq_ctrl_if #(.N_SRC(NS), .ID_W(IW)) bus ();

  irq_ctrl #(.N_SRC(NS), .ID_W(IW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int unsigned exp_q[$];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    tick();
    bus.wr_en   = 1'b0;
    bus.wr_data = '0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    bus.rd_addr = a;
    #1;
    d = bus.rd_data;
  endtask

  task automatic wait_ir(input logic lvl, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      if (bus.ir_in === lvl) ok = 1'b1;
      else tick();
    end
    if (!ok && bus.ir_in === lvl) ok = 1'b1;
  endtask

  task automatic service;
    bus.ir_taken = 1'b1;
    tick();
    bus.ir_taken = 1'b0;
    bus.eret     = 1'b1;
    tick();
    bus.eret     = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    bus.irq_src = '0; bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.rd_addr = '0; bus.ir_taken = 1'b0; bus.eret = 1'b0;
    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    total++; if (bus.ir_in !== 1'b0) begin bad++; $display("FAIL reset_ir_in got=%0b exp=0", bus.ir_in); end
    total++; if (bus.irq_id !== 4'd0) begin bad++; $display("FAIL reset_irq_id got=%0d exp=0", bus.irq_id); end
    rd(IRQ_ADDR_MASK, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL reset_mask got=%h exp=0", d); end
    rd(IRQ_ADDR_PEND, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL reset_pend got=%h exp=0", d); end
  endtask

  task automatic test_edge_latency;
    logic [31:0] d;
    bit ok;
    int unsigned e;
    wr(IRQ_ADDR_MASK, 32'h05);
    exp_q.push_back(2);
    bus.irq_src[2] = 1'b1;
    repeat (2) tick();
    rd(IRQ_ADDR_PEND, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL lat_pend_early got=%h exp=0", d); end
    tick();
    rd(IRQ_ADDR_PEND, d);
    total++; if (d !== 32'h04) begin bad++; $display("FAIL lat_pend_3cyc got=%h exp=04", d); end
    total++; if (bus.ir_in !== 1'b0) begin bad++; $display("FAIL lat_ir_early got=%0b exp=0", bus.ir_in); end
    wait_ir(1'b1, 5, ok);
    total++; if (!ok) begin bad++; $display("FAIL lat_ir_rise got=timeout exp=1"); end
    e = exp_q.pop_front();
    total++; if (32'(bus.irq_id) !== e) begin bad++; $display("FAIL lat_id got=%0d exp=%0d", bus.irq_id, e); end
    rd(IRQ_ADDR_ID, d);
    total++; if (d !== 32'h8000_0002) begin bad++; $display("FAIL lat_id_reg got=%h exp=80000002", d); end
    bus.irq_src[2] = 1'b0;
    service();
    total++; if (bus.ir_in !== 1'b0) begin bad++; $display("FAIL lat_gap got=%0b exp=0", bus.ir_in); end
    rd(IRQ_ADDR_PEND, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL lat_pend_clr got=%h exp=0", d); end
    tick();
    rd(IRQ_ADDR_ID, d);
    total++; if (d !== 32'h2) begin bad++; $display("FAIL lat_id_idle got=%h exp=2", d); end
  endtask

  task automatic test_mask_level;
    logic [31:0] d;
    bus.irq_src[1] = 1'b1;
    repeat (4) tick();
    rd(IRQ_ADDR_PEND, d);
    total++; if (d !== 32'h02) begin bad++; $display("FAIL mask_pend got=%h exp=02", d); end
    total++; if (bus.ir_in !== 1'b0) begin bad++; $display("FAIL mask_no_req got=%0b exp=0", bus.ir_in); end
    bus.eret = 1'b1; tick(); bus.eret = 1'b0;
    bus.ir_taken = 1'b1; tick(); bus.ir_taken = 1'b0;
    rd(IRQ_ADDR_PEND, d);
    total++; if (d !== 32'h02) begin bad++; $display("FAIL idle_eret_ignored got=%h exp=02", d); end
    wr(IRQ_ADDR_PEND, 32'h02);
    repeat (5) tick();
    rd(IRQ_ADDR_PEND, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL level_no_repend got=%h exp=0", d); end
    bus.irq_src[1] = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_priority;
    logic [31:0] d;
    bit ok;
    int unsigned e;
    wr(IRQ_ADDR_MASK, 32'hFF);
    exp_q.push_back(0);
    exp_q.push_back(2);
    bus.irq_src = 8'h05;
    wait_ir(1'b1, 8, ok);
    total++; if (!ok) begin bad++; $display("FAIL prio_ir got=timeout exp=1"); end
    e = exp_q.pop_front();
    total++; if (32'(bus.irq_id) !== e) begin bad++; $display("FAIL prio_first got=%0d exp=%0d", bus.irq_id, e); end
    bus.irq_src = 8'h00;
    service();
    total++; if (bus.ir_in !== 1'b0) begin bad++; $display("FAIL prio_gap got=%0b exp=0", bus.ir_in); end
    tick();
    total++; if (bus.ir_in !== 1'b0) begin bad++; $display("FAIL prio_idle got=%0b exp=0", bus.ir_in); end
    tick();
    total++; if (bus.ir_in !== 1'b1) begin bad++; $display("FAIL prio_rereq got=%0b exp=1", bus.ir_in); end
    e = exp_q.pop_front();
    total++; if (32'(bus.irq_id) !== e) begin bad++; $display("FAIL prio_second got=%0d exp=%0d", bus.irq_id, e); end
    service();
    repeat (3) tick();
    rd(IRQ_ADDR_PEND, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL prio_pend_end got=%h exp=0", d); end
  endtask

  task automatic test_withdraw;
    logic [31:0] d;
    bit ok;
    int unsigned e;
    exp_q.push_back(3);
    bus.irq_src[3] = 1'b1;
    wait_ir(1'b1, 8, ok);
    total++; if (!ok) begin bad++; $display("FAIL wd_ir got=timeout exp=1"); end
    e = exp_q.pop_front();
    total++; if (32'(bus.irq_id) !== e) begin bad++; $display("FAIL wd_id got=%0d exp=%0d", bus.irq_id, e); end
    bus.irq_src[3] = 1'b0;
    wr(IRQ_ADDR_PEND, 32'h08);
    total++; if (bus.ir_in !== 1'b1) begin bad++; $display("FAIL wd_still_req got=%0b exp=1", bus.ir_in); end
    tick();
    total++; if (bus.ir_in !== 1'b0) begin bad++; $display("FAIL wd_gap got=%0b exp=0", bus.ir_in); end
    rd(IRQ_ADDR_ID, d);
    total++; if (d !== 32'h3) begin bad++; $display("FAIL wd_id_reg got=%h exp=3", d); end
    repeat (3) tick();
    total++; if (bus.ir_in !== 1'b0) begin bad++; $display("FAIL wd_stays_low got=%0b exp=0", bus.ir_in); end
  endtask

  task automatic test_resvc;
    logic [31:0] d;
    bit ok;
    int unsigned e;
    exp_q.push_back(1);
    bus.irq_src[1] = 1'b1;
    wait_ir(1'b1, 8, ok);
    total++; if (!ok) begin bad++; $display("FAIL resvc_ir got=timeout exp=1"); end
    e = exp_q.pop_front();
    total++; if (32'(bus.irq_id) !== e) begin bad++; $display("FAIL resvc_id got=%0d exp=%0d", bus.irq_id, e); end
    bus.irq_src[1] = 1'b0;
    bus.ir_taken = 1'b1; tick(); bus.ir_taken = 1'b0;
    repeat (2) tick();
    bus.irq_src[1] = 1'b1;
    repeat (3) tick();
    bus.irq_src[1] = 1'b0;
    exp_q.push_back(1);
    bus.eret = 1'b1; tick(); bus.eret = 1'b0;
    total++; if (bus.ir_in !== 1'b0) begin bad++; $display("FAIL resvc_gap got=%0b exp=0", bus.ir_in); end
    rd(IRQ_ADDR_PEND, d);
    total++; if (d !== 32'h02) begin bad++; $display("FAIL resvc_pend got=%h exp=02", d); end
    wait_ir(1'b1, 4, ok);
    total++; if (!ok) begin bad++; $display("FAIL resvc_rereq got=timeout exp=1"); end
    e = exp_q.pop_front();
    total++; if (32'(bus.irq_id) !== e) begin bad++; $display("FAIL resvc_id2 got=%0d exp=%0d", bus.irq_id, e); end
    service();
    repeat (2) tick();
    rd(IRQ_ADDR_PEND, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL resvc_pend_end got=%h exp=0", d); end
  endtask

  task automatic test_timer;
    logic [31:0] d;
`ifdef IRQ_TIMER_EN
    bit ok;
    int unsigned e;
    wr(IRQ_ADDR_MASK, 32'(1) << NS);
    wr(IRQ_ADDR_TCMP, 32'd10);
    rd(IRQ_ADDR_TCMP, d);
    total++; if (d !== 32'd10) begin bad++; $display("FAIL tmr_tcmp got=%h exp=a", d); end
    exp_q.push_back(NS);
    wait_ir(1'b1, 40, ok);
    total++; if (!ok) begin bad++; $display("FAIL tmr_ir got=timeout exp=1"); end
    e = exp_q.pop_front();
    total++; if (32'(bus.irq_id) !== e) begin bad++; $display("FAIL tmr_id got=%0d exp=%0d", bus.irq_id, e); end
    wr(IRQ_ADDR_TCMP, 32'd0);
    service();
    wr(IRQ_ADDR_PEND, 32'h1FF);
    tick();
    rd(IRQ_ADDR_PEND, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL tmr_pend_end got=%h exp=0", d); end
`else
    wr(IRQ_ADDR_TCMP, 32'hDEAD);
    rd(IRQ_ADDR_TCMP, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL tcmp_absent got=%h exp=0", d); end
`endif
  endtask

  task automatic test_async_reset;
    logic [31:0] d;
    bit ok;
    int unsigned e;
    wr(IRQ_ADDR_MASK, 32'hFF);
    exp_q.push_back(5);
    bus.irq_src[5] = 1'b1;
    wait_ir(1'b1, 8, ok);
    total++; if (!ok) begin bad++; $display("FAIL ar_ir got=timeout exp=1"); end
    e = exp_q.pop_front();
    total++; if (32'(bus.irq_id) !== e) begin bad++; $display("FAIL ar_id got=%0d exp=%0d", bus.irq_id, e); end
    bus.irq_src[5] = 1'b0;
    bus.ir_taken = 1'b1; tick(); bus.ir_taken = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    total++; if (bus.ir_in !== 1'b0) begin bad++; $display("FAIL ar_ir_in got=%0b exp=0", bus.ir_in); end
    rd(IRQ_ADDR_MASK, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL ar_mask got=%h exp=0", d); end
    rd(IRQ_ADDR_PEND, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL ar_pend got=%h exp=0", d); end
    rd(IRQ_ADDR_ID, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL ar_id_reg got=%h exp=0", d); end
    tick();
    rst = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_edge_latency();
    test_mask_level();
    test_priority();
    test_withdraw();
    test_resvc();
    test_timer();
    test_async_reset();
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL sb_leftover got=%0d exp=0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
